alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 109 ++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared registered ALU
module alu_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [2:0] req0_op,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  output logic       req0_ready,
  output logic       resp0_valid,
  input  logic       resp0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_op,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  output logic       req1_ready,
  output logic       resp1_valid,
  input  logic       resp1_ready,
  output logic [7:0] resp_data,
  output logic       resp_zf,
  output logic       resp_cf,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [2:0] alu_control,
  output logic       alu_execute,
  input  logic [7:0] alu_out,
  input  logic       alu_zf,
  input  logic       alu_cf,
  output logic       busy,
  output logic [7:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, CAPTURE, RESP} state_t;

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   grant0;
  logic   grant1;
  logic   handshake;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant0    = req0_valid && (!req1_valid || last_grant);
    grant1    = req1_valid && (!req0_valid || !last_grant);
    handshake = owner ? resp1_ready : resp0_ready;
  end

  assign req0_ready = !reset && (state == IDLE) && grant0;
  assign req1_ready = !reset && (state == IDLE) && grant1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      alu_control <= 3'b000;
      alu_execute <= 1'b0;
      resp_data   <= 8'h00;
      resp_zf     <= 1'b0;
      resp_cf     <= 1'b0;
      resp0_valid <= 1'b0;
      resp1_valid <= 1'b0;
      busy        <= 1'b0;
      op_count    <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            alu_control <= grant1 ? req1_op : req0_op;
            alu_a       <= grant1 ? req1_a  : req0_a;
            alu_b       <= grant1 ? req1_b  : req0_b;
            owner       <= grant1;
            last_grant  <= grant1;
            alu_execute <= 1'b1;
            busy        <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          alu_execute <= 1'b0;
          state       <= CAPTURE;
        end
        CAPTURE: begin
          // ALU result registered on the EXEC edge is valid now.
          resp_data   <= alu_out;
          resp_zf     <= alu_zf;
          resp_cf     <= alu_cf;
          resp0_valid <= !owner;
          resp1_valid <= owner;
          state       <= RESP;
        end
        RESP: begin
          if (handshake) begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            op_count    <= op_count + 8'd1;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter with a behavioural ALU
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [1:0] resp_ready = 2'b00;
  logic [2:0] req_op [2];
  logic [7:0] req_a [2];
  logic [7:0] req_b [2];
  wire  [1:0] req_ready;
  wire  [1:0] resp_valid;
  wire  [7:0] resp_data, alu_a, alu_b, op_count;
  wire        resp_zf, resp_cf, alu_execute, busy;
  wire  [2:0] alu_control;
  logic [7:0] alu_out = 8'h00;
  logic       alu_zf = 1'b0;
  logic       alu_cf = 1'b0;
  wire  [8:0] alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
  wire  [8:0] alu_dif = {1'b0, alu_a} - {1'b0, alu_b};

  int total = 0;
  int bad = 0;
  int exp_count = 0;
  int ref_z = 0;
  int ref_c = 0;

  always #5 clk = ~clk;

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req_valid[0]), .req0_op(req_op[0]), .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req0_ready(req_ready[0]), .resp0_valid(resp_valid[0]), .resp0_ready(resp_ready[0]),
    .req1_valid(req_valid[1]), .req1_op(req_op[1]), .req1_a(req_a[1]), .req1_b(req_b[1]),
    .req1_ready(req_ready[1]), .resp1_valid(resp_valid[1]), .resp1_ready(resp_ready[1]),
    .resp_data(resp_data), .resp_zf(resp_zf), .resp_cf(resp_cf),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_execute(alu_execute),
    .alu_out(alu_out), .alu_zf(alu_zf), .alu_cf(alu_cf),
    .busy(busy), .op_count(op_count)
  );

  // External ALU: result registered on the execute edge; only add/sub touch flags.
  always @(posedge clk) begin
    if (alu_execute) begin
      case (alu_control)
        3'b000: alu_out <= alu_a & alu_b;
        3'b001: alu_out <= alu_a | alu_b;
        3'b010: alu_out <= alu_a ^ alu_b;
        3'b011: alu_out <= ~alu_a;
        3'b100: alu_out <= {alu_a[6:0], 1'b0};
        3'b101: alu_out <= {alu_a[3:0], alu_b[3:0]};
        3'b110: begin
          alu_out <= alu_sum[7:0];
          alu_cf  <= alu_sum[8];
          alu_zf  <= (alu_sum[7:0] == 8'h00);
        end
        default: begin
          alu_out <= alu_dif[7:0];
          alu_cf  <= alu_dif[8];
          alu_zf  <= (alu_dif[7:0] == 8'h00);
        end
      endcase
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference written from the operation definitions with integer arithmetic.
  task automatic model(input int op, input int a, input int b, output int d);
    case (op)
      0: d = a & b;
      1: d = a | b;
      2: d = a ^ b;
      3: d = 255 - a;
      4: d = (a * 2) % 256;
      5: d = (a % 16) * 16 + (b % 16);
      6: begin d = (a + b) % 256; ref_c = (a + b > 255); ref_z = (d == 0); end
      default: begin d = (a - b + 256) % 256; ref_c = (a < b); ref_z = (a == b); end
    endcase
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    req_valid = 2'b00;
    resp_ready = 2'b00;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_count = 0;
  endtask

  // Entered and left one time unit after a rising edge.
  task automatic run_one(input int n, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input int hold, input logic [7:0] ed, input logic ez, input logic ec);
    int w, lat, ex;
    int o;
    logic [7:0] d;
    o = 1 - n;
    req_op[n] = op;
    req_a[n] = a;
    req_b[n] = b;
    req_valid[n] = 1'b1;
    #1;
    w = 0;
    while (!req_ready[n] && w < 20) begin
      @(posedge clk); #2;
      w++;
    end
    chk("grant_wait", w, 0);
    if (w >= 20) begin
      req_valid[n] = 1'b0;
      return;
    end
    chk("ready_exclusive", int'(req_ready[o]), 0);
    @(posedge clk); #1;
    req_valid[n] = 1'b0;
    chk("alu_control", int'(alu_control), int'(op));
    chk("alu_a", int'(alu_a), int'(a));
    chk("alu_b", int'(alu_b), int'(b));
    lat = 1;
    ex = 0;
    while (!resp_valid[n] && lat < 10) begin
      ex += int'(alu_execute);
      chk("ready_blocked", int'(req_ready[o]), 0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3);
    chk("exec_cycles", ex, 1);
    chk("exec_off_resp", int'(alu_execute), 0);
    chk("resp_data", int'(resp_data), int'(ed));
    chk("resp_zf", int'(resp_zf), int'(ez));
    chk("resp_cf", int'(resp_cf), int'(ec));
    chk("resp_other", int'(resp_valid[o]), 0);
    chk("busy_resp", int'(busy), 1);
    d = resp_data;
    for (int h = 0; h < hold; h++) begin
      resp_ready[o] = 1'b1;
      @(posedge clk); #1;
      chk("hold_data", int'(resp_data), int'(d));
      chk("hold_flags", int'({resp_zf, resp_cf}), int'({ez, ec}));
      chk("hold_valid", int'(resp_valid[n]), 1);
      chk("hold_busy", int'(busy), 1);
      chk("hold_no_grant", int'(req_ready[o]), 0);
    end
    resp_ready[o] = 1'b0;
    resp_ready[n] = 1'b1;
    @(posedge clk); #1;
    resp_ready[n] = 1'b0;
    exp_count++;
    chk("resp_drop", int'(resp_valid[n]), 0);
    chk("busy_idle", int'(busy), 0);
    chk("op_count", int'(op_count), exp_count % 256);
  endtask

  typedef struct {
    int         n;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    int         hold;
    logic [7:0] d;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vt [11];

  initial begin
    int g [$];
    int d;
    int n, op, a, b;

    vt[0]  = '{0, 3'b110, 8'h05, 8'h03, 0, 8'h08, 1'b0, 1'b0};
    vt[1]  = '{1, 3'b111, 8'h03, 8'h05, 1, 8'hFE, 1'b0, 1'b1};
    vt[2]  = '{1, 3'b111, 8'h42, 8'h42, 0, 8'h00, 1'b1, 1'b0};
    vt[3]  = '{0, 3'b000, 8'hF0, 8'h3C, 2, 8'h30, 1'b1, 1'b0};
    vt[4]  = '{1, 3'b110, 8'hFF, 8'h01, 0, 8'h00, 1'b1, 1'b1};
    vt[5]  = '{0, 3'b101, 8'hA5, 8'h3C, 3, 8'h5C, 1'b1, 1'b1};
    vt[6]  = '{1, 3'b010, 8'hAA, 8'h55, 0, 8'hFF, 1'b1, 1'b1};
    vt[7]  = '{0, 3'b110, 8'h10, 8'h20, 1, 8'h30, 1'b0, 1'b0};
    vt[8]  = '{1, 3'b011, 8'h0F, 8'h00, 0, 8'hF0, 1'b0, 1'b0};
    vt[9]  = '{0, 3'b100, 8'h81, 8'h00, 0, 8'h02, 1'b0, 1'b0};
    vt[10] = '{1, 3'b001, 8'h12, 8'h40, 2, 8'h52, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      req_op[i] = 3'b000;
      req_a[i] = 8'h00;
      req_b[i] = 8'h00;
    end

    // Reset state while reset is still held.
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_resp_valid", int'(resp_valid), 0);
    chk("rst_exec", int'(alu_execute), 0);
    chk("rst_op_count", int'(op_count), 0);
    chk("rst_alu_ab", int'({alu_a, alu_b, alu_control}), 0);
    chk("rst_resp", int'({resp_data, resp_zf, resp_cf}), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 11; i++)
      run_one(vt[i].n, vt[i].op, vt[i].a, vt[i].b, vt[i].hold, vt[i].d, vt[i].z, vt[i].c);

    // Stalled response: req1 waits behind an unconsumed req0 result.
    do_reset();
    req_op[1] = 3'b111;
    req_a[1] = 8'h09;
    req_b[1] = 8'h04;
    req_valid[1] = 1'b1;
    run_one(0, 3'b110, 8'h20, 8'h22, 5, 8'h42, 1'b0, 1'b0);
    chk("req1_after_stall", int'(req_ready[1]), 1);
    run_one(1, 3'b111, 8'h09, 8'h04, 0, 8'h05, 1'b0, 1'b0);

    // Both held valid from reset: grants alternate starting with req0.
    do_reset();
    resp_ready = 2'b11;
    req_valid = 2'b11;
    #1;
    for (int cyc = 0; cyc < 60 && g.size() < 3; cyc++) begin
      chk("ready_exclusive_rr", int'(req_ready == 2'b11), 0);
      if (req_ready[0]) g.push_back(0);
      else if (req_ready[1]) g.push_back(1);
      @(posedge clk); #2;
    end
    req_valid = 2'b00;
    repeat (6) @(posedge clk);
    #1;
    resp_ready = 2'b00;
    chk("rr_grants", g.size(), 3);
    if (g.size() == 3) begin
      chk("rr_first", g[0], 0);
      chk("rr_second", g[1], 1);
      chk("rr_third", g[2], 0);
    end
    chk("rr_op_count", int'(op_count), 3);

    // Reset in EXEC discards the operation.
    do_reset();
    req_op[0] = 3'b110;
    req_a[0] = 8'h01;
    req_b[0] = 8'h02;
    req_valid[0] = 1'b1;
    #1;
    chk("first_edge_ready", int'(req_ready[0]), 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("exec_high", int'(alu_execute), 1);
    reset = 1'b1;
    #1;
    chk("rst_exec_async", int'(alu_execute), 0);
    chk("rst_busy_async", int'(busy), 0);
    chk("rst_op_count_mid", int'(op_count), 0);
    @(posedge clk); #1;
    reset = 1'b0;
    exp_count = 0;
    for (int i = 0; i < 5; i++) begin
      chk("no_resp_after_rst", int'(resp_valid), 0);
      @(posedge clk); #1;
    end
    run_one(0, 3'b110, 8'h01, 8'h02, 0, 8'h03, 1'b0, 1'b0);

    // Random traffic against the model, running op_count up to the wrap.
    do_reset();
    for (int i = 0; i < 255; i++) begin
      n = $urandom_range(0, 1);
      op = (i == 0) ? 7 : $urandom_range(0, 7);
      a = $urandom_range(0, 255);
      b = (i % 7 == 3) ? a : $urandom_range(0, 255);
      model(op, a, b, d);
      run_one(n, op[2:0], a[7:0], b[7:0], $urandom_range(0, 2), d[7:0], ref_z[0], ref_c[0]);
    end
    chk("count_255", int'(op_count), 255);
    model(6, 8'h80, 8'h80, d);
    run_one(1, 3'b110, 8'h80, 8'h80, 0, d[7:0], ref_z[0], ref_c[0]);
    chk("count_wrap", int'(op_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
